// File: rtl/epcs_flash_responder_if.sv
// rtl/epcs_flash_responder_if.sv - EPCS serial link and backing-memory port bundle
interface epcs_flash_responder_if #(
  parameter int MEM_AW = 16
);
  logic              epcs_dclk;
  logic              epcs_sce;
  logic              epcs_sdo;
  logic              epcs_data0;
  logic [MEM_AW-1:0] mem_addr;
  logic              mem_rd;
  logic [7:0]        mem_rdata;
  logic              mem_wr;
  logic [7:0]        mem_wdata;

  modport master (
    output epcs_dclk, epcs_sce, epcs_sdo, mem_rdata,
    input  epcs_data0, mem_addr, mem_rd, mem_wr, mem_wdata
  );

  modport slave (
    input  epcs_dclk, epcs_sce, epcs_sdo, mem_rdata,
    output epcs_data0, mem_addr, mem_rd, mem_wr, mem_wdata
  );
endinterface

// File: rtl/epcs_flash_responder.sv
// rtl/epcs_flash_responder.sv - EPCS serial-flash device model serving a byte-wide memory port
// Optional EPCS_RESP_SILICON_ID_EN: opcode 0xAB returns SILICON_ID after 3 dummy bytes.
module epcs_flash_responder #(
  parameter int         MEM_AW      = 16,
  parameter int         PROG_CYCLES = 1024,
  parameter logic [7:0] SILICON_ID  = 8'h14
) (
  input  logic                  clk_clk,
  input  logic                  reset_n_reset_n,
  epcs_flash_responder_if.slave epcs,
  output logic                  busy
);
  typedef enum logic [3:0] {
    IDLE, CMD, ADDR, RD_DATA, WR_DATA, STATUS, ID_DUMMY, ID_OUT, IGNORE
  } state_t;

  localparam int CW = $clog2(PROG_CYCLES + 1);

  state_t            state, next_state;
  logic [1:0]        dclk_sync, sce_sync, sdo_sync;
  logic              dclk_d, sce_d;
  logic              dclk_s, sce_s, sdo_s;
  logic              rise, fall, sce_rise, byte_done;
  logic [2:0]        bit_cnt;
  logic [1:0]        byte_cnt;
  logic [6:0]        shift_in;
  logic [7:0]        in_byte, shift_out, out_src;
  logic [MEM_AW-2:0] addr_sr;
  logic              op_prog;
  logic              data0_q, mem_rd_q, mem_wr_q, rd_q;
  logic [MEM_AW-1:0] mem_addr_q;
  logic [7:0]        mem_wdata_q;
  logic              wel, wip;
  logic [CW-1:0]     prog_cnt;
  logic              pend_wren, pend_wrdi, wrote;
  logic              do_fetch, do_write, addr_load, load_stat, load_id, set_wren, set_wrdi;

  assign dclk_s    = dclk_sync[1];
  assign sce_s     = sce_sync[1];
  assign sdo_s     = sdo_sync[1];
  assign rise      = ~sce_s & dclk_s & ~dclk_d;
  assign fall      = ~sce_s & ~dclk_s & dclk_d;
  assign sce_rise  = sce_s & ~sce_d;
  assign byte_done = rise & (bit_cnt == 3'd7);
  assign in_byte   = {shift_in, sdo_s};
  // Read data arrives one cycle after mem_rd; a fall landing in that cycle takes it directly.
  assign out_src   = rd_q ? epcs.mem_rdata : shift_out;

  assign epcs.epcs_data0 = data0_q;
  assign epcs.mem_addr   = mem_addr_q;
  assign epcs.mem_rd     = mem_rd_q;
  assign epcs.mem_wr     = mem_wr_q;
  assign epcs.mem_wdata  = mem_wdata_q;
  assign busy            = wip;

  always_comb begin
    next_state = state;
    do_fetch   = 1'b0;
    do_write   = 1'b0;
    addr_load  = 1'b0;
    load_stat  = 1'b0;
    load_id    = 1'b0;
    set_wren   = 1'b0;
    set_wrdi   = 1'b0;
    if (sce_s) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE, CMD: begin
          next_state = CMD;
          if (byte_done) begin
            if (wip && in_byte != 8'h05) begin
              next_state = IGNORE;
            end else begin
              case (in_byte)
                8'h03: next_state = ADDR;
                8'h02: next_state = wel ? ADDR : IGNORE;
                8'h05: begin
                  next_state = STATUS;
                  load_stat  = 1'b1;
                end
                8'h06: begin
                  next_state = IGNORE;
                  set_wren   = 1'b1;
                end
                8'h04: begin
                  next_state = IGNORE;
                  set_wrdi   = 1'b1;
                end
`ifdef EPCS_RESP_SILICON_ID_EN
                8'hAB: next_state = ID_DUMMY;
`endif
                default: next_state = IGNORE;
              endcase
            end
          end
        end
        ADDR: begin
          if (byte_done && byte_cnt == 2'd2) begin
            next_state = op_prog ? WR_DATA : RD_DATA;
            addr_load  = 1'b1;
            do_fetch   = ~op_prog;
          end
        end
        RD_DATA:  do_fetch  = byte_done;
        WR_DATA:  do_write  = byte_done;
        STATUS:   load_stat = byte_done;
        ID_DUMMY: begin
          if (byte_done && byte_cnt == 2'd2) begin
            next_state = ID_OUT;
            load_id    = 1'b1;
          end
        end
        ID_OUT:   load_id = byte_done;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_n_reset_n) begin
      state       <= IDLE;
      dclk_sync   <= 2'b00;
      sce_sync    <= 2'b11;
      sdo_sync    <= 2'b00;
      dclk_d      <= 1'b0;
      sce_d       <= 1'b1;
      bit_cnt     <= '0;
      byte_cnt    <= '0;
      shift_in    <= '0;
      shift_out   <= '0;
      addr_sr     <= '0;
      op_prog     <= 1'b0;
      data0_q     <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      rd_q        <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      wel         <= 1'b0;
      wip         <= 1'b0;
      prog_cnt    <= '0;
      pend_wren   <= 1'b0;
      pend_wrdi   <= 1'b0;
      wrote       <= 1'b0;
    end else begin
      dclk_sync <= {dclk_sync[0], epcs.epcs_dclk};
      sce_sync  <= {sce_sync[0], epcs.epcs_sce};
      sdo_sync  <= {sdo_sync[0], epcs.epcs_sdo};
      dclk_d    <= dclk_s;
      sce_d     <= sce_s;
      state     <= next_state;
      mem_rd_q  <= do_fetch;
      mem_wr_q  <= do_write;
      rd_q      <= mem_rd_q;

      if (sce_s) begin
        bit_cnt   <= '0;
        byte_cnt  <= '0;
        data0_q   <= 1'b0;
        pend_wren <= 1'b0;
        pend_wrdi <= 1'b0;
        wrote     <= 1'b0;
      end else if (rise) begin
        bit_cnt  <= bit_cnt + 3'd1;
        shift_in <= in_byte[6:0];
        addr_sr  <= {addr_sr[MEM_AW-3:0], sdo_s};
        if (bit_cnt == 3'd7 && (state == ADDR || state == ID_DUMMY))
          byte_cnt <= byte_cnt + 2'd1;
        if (byte_done && (state == IDLE || state == CMD))
          op_prog <= (in_byte == 8'h02);
      end else if (fall) begin
        data0_q <= (state == RD_DATA || state == STATUS || state == ID_OUT) && out_src[7];
      end

      if (load_stat)    shift_out <= {6'b0, wel, wip};
      else if (load_id) shift_out <= SILICON_ID;
      else if (fall)    shift_out <= {out_src[6:0], 1'b0};
      else if (rd_q)    shift_out <= epcs.mem_rdata;

      if (set_wren) pend_wren <= 1'b1;
      if (set_wrdi) pend_wrdi <= 1'b1;
      if (do_write) begin
        mem_wdata_q <= in_byte;
        wrote       <= 1'b1;
      end

      // Program address advances after each write and wraps inside the 256-byte page.
      if (addr_load)     mem_addr_q      <= {addr_sr, sdo_s};
      else if (do_fetch) mem_addr_q      <= mem_addr_q + MEM_AW'(1);
      else if (mem_wr_q) mem_addr_q[7:0] <= mem_addr_q[7:0] + 8'd1;

      if (sce_rise && wrote) begin
        wip      <= 1'b1;
        prog_cnt <= CW'(PROG_CYCLES);
      end else if (wip) begin
        prog_cnt <= prog_cnt - CW'(1);
        if (prog_cnt == CW'(1)) wip <= 1'b0;
      end

      if (sce_rise) begin
        if (wrote)          wel <= 1'b0;
        else if (pend_wren) wel <= 1'b1;
        else if (pend_wrdi) wel <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_epcs_flash_responder.sv
// tb/tb_epcs_flash_responder.sv - scoreboard bench for epcs_flash_responder
module tb_epcs_flash_responder;
  localparam int PROG = 800;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic busy;
  int   total = 0;
  int   bad = 0;
  int   busy_cycles = 0;

  logic [15:0] exp_rd [$];
  logic [23:0] exp_wr [$];
  logic [7:0]  exp_rx [$];
  logic [7:0]  got_rx [$];
  logic [7:0]  txb [$];

  epcs_flash_responder_if #(.MEM_AW(16)) bus ();

  epcs_flash_responder #(
    .MEM_AW(16), .PROG_CYCLES(PROG), .SILICON_ID(8'h14)
  ) dut (
    .clk_clk(clk), .reset_n_reset_n(resetn), .epcs(bus.slave), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_init(input logic [15:0] a);
    case (a)
      16'h0100: return 8'hA5;
      16'h0101: return 8'h3C;
      16'hFFFF: return 8'h5A;
      16'h0000: return 8'hC3;
      default:  return 8'h00;
    endcase
  endfunction

  always @(posedge clk) if (bus.mem_rd) bus.mem_rdata <= mem_init(bus.mem_addr);

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input int act);
    total++;
    bad++;
    $display("FAIL %s: got %0h expected nothing", name, act);
  endtask

  initial forever begin
    @(negedge clk);
    if (busy) busy_cycles++;
    if (bus.mem_rd && bus.mem_wr) unexpected("rd_wr_same_cycle", int'(bus.mem_addr));
    if (bus.mem_rd) begin
      if (exp_rd.size() == 0) unexpected("mem_rd_extra", int'(bus.mem_addr));
      else chk("mem_rd_addr", int'(bus.mem_addr), int'(exp_rd.pop_front()));
    end
    if (bus.mem_wr) begin
      if (exp_wr.size() == 0) unexpected("mem_wr_extra", int'({bus.mem_addr, bus.mem_wdata}));
      else chk("mem_wr_addr_data", int'({bus.mem_addr, bus.mem_wdata}), int'(exp_wr.pop_front()));
    end
    while (got_rx.size() > 0) begin
      if (exp_rx.size() == 0) unexpected("rx_extra", int'(got_rx.pop_front()));
      else chk("rx_byte", int'(got_rx.pop_front()), int'(exp_rx.pop_front()));
    end
  end

  // Mode 0 master: bytes from txb, rx bits sampled just before each rising edge.
  // rises_last < 8 stops clocking part-way through the final byte.
  task automatic xact(input int chk_from, input int rises_last);
    logic [7:0] rx;
    int n;
    n = txb.size();
    @(negedge clk);
    bus.epcs_sce = 1'b0;
    #40;
    for (int b = 0; b < n; b++) begin
      for (int i = 7; i >= 0; i--) begin
        bus.epcs_sdo = txb[b][i];
        #40;
        rx[i] = bus.epcs_data0;
        if (b < n - 1 || (7 - i) < rises_last) begin
          bus.epcs_dclk = 1'b1;
          #40;
          bus.epcs_dclk = 1'b0;
        end
      end
      if (b >= chk_from) got_rx.push_back(rx);
    end
    #40;
    bus.epcs_sce = 1'b1;
    #200;
    txb.delete();
  endtask

  task automatic read_status(input logic [7:0] exp);
    exp_rx.push_back(exp);
    txb = '{8'h05, 8'h00};
    xact(1, 8);
  endtask

  task automatic one_byte_cmd(input logic [7:0] op);
    txb = '{op};
    xact(1, 8);
  endtask

  initial begin
    bus.epcs_sce  = 1'b1;
    bus.epcs_dclk = 1'b0;
    bus.epcs_sdo  = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_data0", int'(bus.epcs_data0), 0);
    chk("rst_mem_rd", int'(bus.mem_rd), 0);
    chk("rst_mem_wr", int'(bus.mem_wr), 0);
    chk("rst_mem_addr", int'(bus.mem_addr), 0);
    chk("rst_mem_wdata", int'(bus.mem_wdata), 0);
    chk("rst_busy", int'(busy), 0);
    resetn = 1'b1;
    repeat (4) @(negedge clk);

    // READ 0x000100, 16 data bits sampled; the 16th rising edge is not clocked.
    exp_rd.push_back(16'h0100);
    exp_rd.push_back(16'h0101);
    exp_rx.push_back(8'hA5);
    exp_rx.push_back(8'h3C);
    txb = '{8'h03, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00};
    xact(4, 7);

    // READ with upper address bits ignored and wrap at 2^16.
    exp_rd.push_back(16'hFFFF);
    exp_rd.push_back(16'h0000);
    exp_rx.push_back(8'h5A);
    exp_rx.push_back(8'hC3);
    txb = '{8'h03, 8'h12, 8'hFF, 8'hFF, 8'h00, 8'h00};
    xact(4, 7);

    one_byte_cmd(8'h06);
    read_status(8'h02);

    busy_cycles = 0;
    exp_wr.push_back(24'h12FF11);
    exp_wr.push_back(24'h120022);
    txb = '{8'h02, 8'h00, 8'h12, 8'hFF, 8'h11, 8'h22};
    xact(6, 8);
    read_status(8'h01);

    // READ while WIP is ignored: data0 held low and no memory access.
    exp_rx.push_back(8'h00);
    txb = '{8'h03, 8'h00, 8'h01, 8'h00, 8'h00};
    xact(4, 8);

    for (int k = 0; k < 3000 && busy; k++) @(negedge clk);
    chk("busy_clears", int'(busy), 0);
    chk("busy_len", busy_cycles, PROG);
    read_status(8'h00);

    // PAGE PROGRAM without WRITE ENABLE.
    busy_cycles = 0;
    txb = '{8'h02, 8'h00, 8'h00, 8'h10, 8'h55};
    xact(5, 8);
    repeat (50) @(negedge clk);
    chk("no_wel_busy", busy_cycles, 0);
    read_status(8'h00);

    // Program byte cut after 5 bits: discarded, WEL kept.
    one_byte_cmd(8'h06);
    busy_cycles = 0;
    txb = '{8'h02, 8'h00, 8'h20, 8'h00, 8'h77};
    xact(5, 5);
    repeat (50) @(negedge clk);
    chk("partial_busy", busy_cycles, 0);
    read_status(8'h02);
    one_byte_cmd(8'h04);
    read_status(8'h00);

`ifdef EPCS_RESP_SILICON_ID_EN
    exp_rx.push_back(8'h14);
`else
    exp_rx.push_back(8'h00);
`endif
    txb = '{8'hAB, 8'h00, 8'h00, 8'h00, 8'h00};
    xact(4, 8);

    repeat (10) @(negedge clk);
    chk("rd_left", exp_rd.size(), 0);
    chk("wr_left", exp_wr.size(), 0);
    chk("rx_left", exp_rx.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
